lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-access stage placed directly downstream of the ALU in the CPU pipeline. It takes the ALU result (as an effective address, or as a plain result for non-memory ops) together with the decoded `alucode`. It then drives a request/grant/response data-memory port, performs byte-lane alignment for stores and lane extraction plus sign or zero extension for loads, and hands one result per instruction to writeback.

## Interface
- `RD_W`, default 5, destination register index width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  execute stage presents an instruction
- `req_ready`  out  1  stage can accept; high only in IDLE
- `alucode`  in  6  ALU operation code from the shared `define.vh` (`ALU_LB` … `ALU_SW`, others)
- `addr`  in  32  ALU result: effective address or pass-through result
- `store_data`  in  32  rs2 value for stores
- `rd`  in  RD_W  destination register
- `mem_req`  out  1  memory request, held until `mem_gnt`
- `mem_we`  out  1  1 = store
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  32  load word
- `resp_valid`  out  1  one-cycle result pulse to writeback
- `resp_data`  out  32  load value, bypass result, or faulting address
- `resp_rd`  out  RD_W  writeback target; 0 for stores and faults
- `misalign`  out  1  fault flag, qualified by `resp_valid`

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- In IDLE, `req_valid`&&`req_ready` latches `alucode`, `addr`, `store_data`, `rd`.
- Memory ops go to REQ. Non-memory ops go to RESP with `resp_data`=`addr`.
- REQ: `mem_req`=1 with stable addr/be/wdata/we.
  - On `mem_gnt`, a load goes to WAIT and a store goes to RESP.
  - Without `mem_gnt`, the FSM stays in REQ.
- WAIT: on `mem_rvalid`, capture the extracted data and go to RESP. Otherwise stay in WAIT.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. Writeback applies no backpressure.
- Stores:
  - SB: `mem_be`=`1<<addr[1:0]`, `mem_wdata`={4{sd[7:0]}}.
  - SH: `mem_be`=`addr[1]?4'b1100:4'b0011`, `mem_wdata`={2{sd[15:0]}}.
  - SW: `mem_be`=4'b1111, `mem_wdata`=sd.
- Loads: byte lane selected by `addr[1:0]`, half lane by `addr[1]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Loads drive `mem_be` as for the matching store width. `mem_we`=0.
- Reset values: state IDLE, `req_ready`=1, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_wdata`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `misalign`=0.

## Timing
- Accept at cycle N gives the earliest response:
  - bypass: `resp_valid` at N+1
  - store: `mem_req` at N+1, `resp_valid` at N+2
  - load: `mem_req` at N+1, `mem_rvalid` at N+2, `resp_valid` at N+3
- Load response is captured at the `mem_rvalid` edge. `mem_rvalid` is ignored outside WAIT.
- `req_ready` falls the cycle after acceptance and rises again the cycle after RESP. At most one instruction is in flight.
- Asserting `rst_n` low in any state returns to IDLE immediately. `mem_req` drops asynchronously and the in-flight access is abandoned with no response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected: LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0.
  - The op skips REQ and goes IDLE→RESP. `mem_req` stays 0.
  - Response carries `misalign`=1, `resp_data`=`addr`, `resp_rd`=0.
- Undefined:
  - No detection. `misalign` is tied 0.
  - Offending low address bits are ignored: halfword uses `addr[1]` only, word uses lane 0.

## Structure
- `alucode` constants stay in shared `define.vh`. Add FSM state encodings (2-bit) and width constants `LSU_BE_W`=4 there.
- One sub-module: `lsu_lane_align`, combinational, containing store replication and byte-enable generation, plus load extraction and extension. The FSM and registers stay in `lsu_mem_stage`.

## Test plan
- SB: `addr`=0x1003, `store_data`=0x000000A5, gnt at first REQ cycle → `mem_addr`=0x1000, `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5, `resp_valid` at N+2, `resp_rd`=0.
- LB/LBU: `addr`=0x2001, `mem_rdata`=0x1234F678 → LB `resp_data`=0xFFFFFFF6, LBU `resp_data`=0x000000F6, `resp_valid` at N+3 when rvalid comes at N+2.
- LH: `addr`=0x2002, `mem_rdata`=0x80017FFF → `resp_data`=0xFFFF8001. `mem_gnt` is withheld 3 cycles: `mem_req` stays high with stable outputs and the response is delayed by 3.
- Bypass: `alucode`=ALU_ADD, `addr`=89, `rd`=5 → `mem_req` never asserts, `resp_valid` at N+1 with `resp_data`=89, `resp_rd`=5.
- Misaligned LW: `addr`=0x3002. With the macro → `misalign`=1, `resp_data`=0x3002, no `mem_req`. Without → `mem_addr`=0x3000, normal load.
- Reset mid-op: `rst_n` low while in WAIT → `mem_req`=0 and `req_ready`=1 immediately. A late `mem_rvalid` after reset release produces no `resp_valid`.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_pkg
//   Shared constants for the LSU memory stage: ALU operation codes (mirrors
//   the codes of the core's define.vh), FSM state encoding, byte-enable width
//   and small op-classification helpers.
//   Optional feature macro used by the stage: LSU_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package lsu_mem_stage_pkg;

  // ALU operation codes (6-bit)
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8;
  localparam logic [5:0] ALU_SLTU = 6'd9;
  localparam logic [5:0] ALU_LB   = 6'd18;
  localparam logic [5:0] ALU_LH   = 6'd19;
  localparam logic [5:0] ALU_LW   = 6'd20;
  localparam logic [5:0] ALU_LBU  = 6'd21;
  localparam logic [5:0] ALU_LHU  = 6'd22;
  localparam logic [5:0] ALU_SB   = 6'd23;
  localparam logic [5:0] ALU_SH   = 6'd24;
  localparam logic [5:0] ALU_SW   = 6'd25;

  localparam int LSU_BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
           (op == ALU_LBU) || (op == ALU_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a_lo);
    logic half_op;
    logic word_op;
    half_op = (op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH);
    word_op = (op == ALU_LW) || (op == ALU_SW);
    return (half_op && a_lo[0]) || (word_op && (a_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational byte-lane logic for the LSU memory stage.
//   Store side: byte enables and lane-replicated write data.
//   Load side : lane extraction plus sign/zero extension.
//   Ports:
//     op         in  6   latched alucode
//     addr_lo    in  2   low address bits selecting the lane
//     store_data in  32  rs2 value
//     rdata      in  32  raw memory read word
//     be         out 4   byte enables (0 for non-memory ops)
//     wdata      out 32  replicated store data (0 for non-store ops)
//     load_data  out 32  extracted/extended load result
// ---------------------------------------------------------------------------
import lsu_mem_stage_pkg::*;

module lsu_lane_align (
  input  logic [5:0]          op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         store_data,
  input  logic [31:0]         rdata,
  output logic [LSU_BE_W-1:0] be,
  output logic [31:0]         wdata,
  output logic [31:0]         load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte enables are shared by loads and stores of the same width.
  // Halfword lane uses addr[1] only, word always lane 0: any misaligned low
  // bits are simply ignored here (trapping is decided upstream).
  always_comb begin
    be = '0;
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: be = 4'b0001 << addr_lo;
      ALU_LH, ALU_LHU, ALU_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      ALU_LW, ALU_SW:          be = 4'b1111;
      default:                 be = '0;
    endcase
  end

  always_comb begin
    wdata = '0;
    case (op)
      ALU_SB:  wdata = {4{store_data[7:0]}};
      ALU_SH:  wdata = {2{store_data[15:0]}};
      ALU_SW:  wdata = store_data;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    case (op)
      ALU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      ALU_LBU: load_data = {24'h0, byte_sel};
      ALU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      ALU_LHU: load_data = {16'h0, half_sel};
      ALU_LW:  load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Memory-access stage after the ALU. Accepts one instruction at a time,
//   issues a request/grant/response data-memory access for loads/stores and
//   returns exactly one result pulse per instruction to writeback.
//
//   Handshakes:
//     req_valid/req_ready : transfer when both are high at a rising edge;
//                           req_ready is high only in IDLE.
//     mem_req/mem_gnt     : mem_req and its addr/be/wdata/we stay stable until
//                           a cycle with mem_gnt high; then the request drops.
//     mem_rvalid          : load data sampled only in WAIT, ignored elsewhere.
//     resp_valid          : single-cycle pulse, writeback cannot stall it.
//
//   Ports: clk, rst_n (async active low); req_valid/req_ready, alucode, addr,
//   store_data, rd from execute; mem_req/we/addr/be/wdata, mem_gnt,
//   mem_rvalid, mem_rdata to data memory; resp_valid/data/rd and misalign to
//   writeback; dbg_state exposes the FSM state.
//
//   Macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
//   accesses skip memory and respond with misalign=1, resp_data=addr, rd=0.
// ---------------------------------------------------------------------------
import lsu_mem_stage_pkg::*;

module lsu_mem_stage #(
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          alucode,
  input  logic [31:0]         addr,
  input  logic [31:0]         store_data,
  input  logic [RD_W-1:0]     rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [LSU_BE_W-1:0] mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                resp_valid,
  output logic [31:0]         resp_data,
  output logic [RD_W-1:0]     resp_rd,
  output logic                misalign,
  output logic [1:0]          dbg_state
);

  lsu_state_e      state_q, state_d;
  logic [5:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     sd_q, sd_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [RD_W-1:0] resp_rd_q, resp_rd_d;
  logic            misalign_q, misalign_d;

  logic            fault_in;
  logic [31:0]     load_data;

  // Alignment works on the latched instruction so memory-side outputs stay
  // stable for the whole REQ phase regardless of what execute presents.
  lsu_lane_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (mem_rdata),
    .be         (mem_be),
    .wdata      (mem_wdata),
    .load_data  (load_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault_in = is_misaligned(alucode, addr[1:0]);
`else
  assign fault_in = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sd_d        = sd_q;
    resp_data_d = resp_data_q;
    resp_rd_d   = resp_rd_q;
    misalign_d  = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = alucode;
          addr_d      = addr;
          sd_d        = store_data;
          misalign_d  = fault_in;
          // Bypass result and faulting address are both the ALU result;
          // a load overwrites this when its data arrives.
          resp_data_d = addr;
          resp_rd_d   = (is_store(alucode) || fault_in) ? '0 : rd;
          if (is_mem(alucode) && !fault_in) state_d = ST_REQ;
          else                              state_d = ST_RESP;
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = is_load(op_q) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          resp_data_d = load_data;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= ALU_ADD;
      addr_q      <= '0;
      sd_q        <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sd_q        <= sd_d;
      resp_data_q <= resp_data_d;
      resp_rd_q   <= resp_rd_d;
      misalign_q  <= misalign_d;
    end
  end

  // Handshake outputs decode the state register directly, so reset clears
  // them asynchronously along with the state.
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_we     = is_store(op_q);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign misalign   = misalign_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        misalign;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_mem_stage #(.RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .alucode(alucode), .addr(addr), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // entry: {check_data, misalign, rd[4:0], data[31:0]}
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[38]) check("resp_word", {misalign, resp_rd, resp_data}, mon_e[37:0]);
        else           check("resp_flags", {misalign, resp_rd}, mon_e[37:32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and let it be accepted at the next edge; the
  // inputs are scrambled afterwards so only latched values can be used.
  task automatic issue(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r);
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; alucode = op; addr = a; store_data = sd; rd = r;
    tick();
    req_valid = 1'b0; alucode = ALU_SW; addr = $urandom; store_data = $urandom;
    rd = 5'($urandom_range(0, 31));
    check("ready_after", req_ready, 0);
  endtask

  task automatic run_store(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input int gnt_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h0});
    issue(op, a, sd, 5'd9);
    for (int i = 0; i <= gnt_delay; i++) begin
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_we"}, mem_we, 1);
      check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_be"}, mem_be, exp_be);
      check({tag, "_wdata"}, mem_wdata, exp_wdata);
      check({tag, "_novalid"}, resp_valid, 0);
      mem_gnt = (i == gnt_delay);
      tick();
    end
    mem_gnt = 1'b0;
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_rd"}, resp_rd, 0);
    check({tag, "_req_drop"}, mem_req, 0);
    tick();
    check({tag, "_resp_end"}, resp_valid, 0);
  endtask

  task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [4:0] r, input int gnt_delay,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [3:0] exp_be);
    exp_q.push_back({1'b1, 1'b0, r, exp_data});
    issue(op, a, 32'h0, r);
    for (int i = 0; i <= gnt_delay; i++) begin
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_be"}, mem_be, exp_be);
      mem_gnt = (i == gnt_delay);
      tick();
    end
    mem_gnt = 1'b0;
    check({tag, "_wait_noreq"}, mem_req, 0);
    check({tag, "_wait_novalid"}, resp_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_data"}, resp_data, exp_data);
    check({tag, "_resp_rd"}, resp_rd, r);
    tick();
    check({tag, "_resp_end"}, resp_valid, 0);
  endtask

  task automatic run_bypass(input string tag, input logic [5:0] op,
                            input logic [31:0] a, input logic [4:0] r);
    exp_q.push_back({1'b1, 1'b0, r, a});
    issue(op, a, 32'h0, r);
    check({tag, "_noreq"}, mem_req, 0);
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_data"}, resp_data, a);
    check({tag, "_resp_rd"}, resp_rd, r);
    tick();
    check({tag, "_resp_end"}, resp_valid, 0);
    check({tag, "_noreq2"}, mem_req, 0);
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic run_fault(input string tag, input logic [5:0] op, input logic [31:0] a);
    exp_q.push_back({1'b1, 1'b1, 5'd0, a});
    issue(op, a, 32'h5555_5555, 5'd7);
    check({tag, "_noreq"}, mem_req, 0);
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_misalign"}, misalign, 1);
    check({tag, "_resp_data"}, resp_data, a);
    check({tag, "_resp_rd"}, resp_rd, 0);
    tick();
    check({tag, "_resp_end"}, resp_valid, 0);
    check({tag, "_noreq2"}, mem_req, 0);
  endtask
`endif

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_rd", resp_rd, 0);
    check("rst_misalign", misalign, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // Stores
    run_store("sb", ALU_SB, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5);
    run_store("sh", ALU_SH, 32'h0000_1006, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
    run_store("sw", ALU_SW, 32'h0000_1008, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);

    // Loads
    run_load("lb",  ALU_LB,  32'h0000_2001, 5'd3, 0, 32'h1234_F678, 32'hFFFF_FFF6, 4'b0010);
    run_load("lbu", ALU_LBU, 32'h0000_2001, 5'd4, 0, 32'h1234_F678, 32'h0000_00F6, 4'b0010);
    run_load("lb3", ALU_LB,  32'h0000_2003, 5'd6, 0, 32'h7F00_0080, 32'h0000_007F, 4'b1000);
    run_load("lh",  ALU_LH,  32'h0000_2002, 5'd8, 3, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1100);
    run_load("lhu", ALU_LHU, 32'h0000_2002, 5'd10, 0, 32'h8001_7FFF, 32'h0000_8001, 4'b1100);
    run_load("lh0", ALU_LH,  32'h0000_2000, 5'd11, 0, 32'h8001_7FFF, 32'h0000_7FFF, 4'b0011);
    run_load("lw",  ALU_LW,  32'h0000_2004, 5'd12, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

    // Bypass
    run_bypass("add", ALU_ADD, 32'd89, 5'd5);
    run_bypass("xor", ALU_XOR, 32'hFFFF_0000, 5'd31);

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    run_fault("lw_mis", ALU_LW, 32'h0000_3002);
    run_fault("sh_mis", ALU_SH, 32'h0000_3001);
    run_fault("lhu_mis", ALU_LHU, 32'h0000_3003);
`else
    run_load("lw_mis", ALU_LW, 32'h0000_3002, 5'd7, 0, 32'h1122_3344, 32'h1122_3344, 4'b1111);
    run_load("lh_mis", ALU_LH, 32'h0000_3003, 5'd13, 0, 32'h9ABC_1234, 32'hFFFF_9ABC, 4'b1100);
    check("nomacro_misalign", misalign, 0);
`endif

    // Reset while in REQ: request must drop without a clock edge
    issue(ALU_SW, 32'h0000_5000, 32'h0000_0001, 5'd3);
    check("rstreq_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstreq_req", mem_req, 0);
    check("rstreq_ready", req_ready, 1);
    check("rstreq_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstreq_idle_req", mem_req, 0);
    check("rstreq_idle_valid", resp_valid, 0);

    // Reset while in WAIT: a late rvalid must not produce a response
    issue(ALU_LW, 32'h0000_6000, 32'h0, 5'd2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rstwait_state", dbg_state, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rstwait_req", mem_req, 0);
    check("rstwait_ready", req_ready, 1);
    check("rstwait_state0", dbg_state, 0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    check("late_rvalid_0", resp_valid, 0);
    tick();
    check("late_rvalid_1", resp_valid, 0);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("late_ready", req_ready, 1);

    // Stage still works after the abandoned access
    run_bypass("post", ALU_SUB, 32'h0000_0042, 5'd1);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
